// File: rtl/vedic_pkg.sv
// Shared types and defaults for the vedic arithmetic datapath.
package vedic_pkg;

  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

  localparam int VEDIC_W_DEFAULT = 4;

endpackage

// File: rtl/vedic_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module vedic_div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] p,
  input  logic         bit_in,
  input  logic [W-1:0] b,
  output logic [W-1:0] p_next,
  output logic         q_bit
);

  logic [W:0] sh;
  logic [W:0] t;

  // The remainder is always below b, so W bits hold it between steps; only the trial needs W+1.
  always_comb begin
    sh     = {p, bit_in};
    t      = sh - {1'b0, b};
    q_bit  = ~t[W];
    p_next = t[W] ? sh[W-1:0] : t[W-1:0];
  end

endmodule

// File: rtl/vedic_seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional VEDIC_DIV_ZERO_ERR_EN adds the err port and a one-cycle divide-by-zero path.
module vedic_seq_divider
  import vedic_pkg::*;
#(
  parameter int W = VEDIC_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done
`ifdef VEDIC_DIV_ZERO_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int CW = $clog2(W + 1);

  div_state_t     state, state_n;
  logic [W-1:0]   p;
  logic [W-1:0]   dq;
  logic [W-1:0]   dv;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   p_next;
  logic           q_bit;
  logic           accept;
  logic           finish;
  logic           zero_div;
  logic [W-1:0]   q_res;
  logic [W-1:0]   r_res;

`ifdef VEDIC_DIV_ZERO_ERR_EN
  assign zero_div = (dv == '0);
`else
  assign zero_div = 1'b0;
`endif

  vedic_div_step #(.W(W)) u_step (
    .p      (p),
    .bit_in (dq[W-1]),
    .b      (dv),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_comb begin
    state_n = state;
    accept  = (state != DIV) && start;
    finish  = (state == DIV) && ((cnt == CW'(1)) || zero_div);
    // dq doubles as dividend shifter and quotient accumulator; unshifted it still holds a.
    q_res   = {dq[W-2:0], q_bit};
    r_res   = p_next;
    if (zero_div) begin
      q_res = '1;
      r_res = dq;
    end
    case (state)
      IDLE:    if (start) state_n = DIV;
      DIV:     if (finish) state_n = DONE;
      DONE:    state_n = start ? DIV : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
      dq    <= '0;
      dv    <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef VEDIC_DIV_ZERO_ERR_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done  <= finish;
      if (accept) begin
        p    <= '0;
        dq   <= a;
        dv   <= b;
        cnt  <= CW'(W);
        busy <= 1'b1;
`ifdef VEDIC_DIV_ZERO_ERR_EN
        err  <= 1'b0;
`endif
      end else if (state == DIV) begin
        p   <= p_next;
        dq  <= {dq[W-2:0], q_bit};
        cnt <= cnt - CW'(1);
        if (finish) begin
          q    <= q_res;
          r    <= r_res;
          busy <= 1'b0;
`ifdef VEDIC_DIV_ZERO_ERR_EN
          err  <= zero_div;
`endif
        end
      end
    end
  end

endmodule
